vend_txn_ctrl: RTL and testbench



---
 rtl/vend_pkg.sv | 17 +
 rtl/vend_credit_acc.sv | 28 ++
 rtl/vend_txn_ctrl.sv | 103 ++++++++++
 tb/tb_vend_txn_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and width defaults for the vending transaction controller.
package vend_pkg;

    localparam int ITEM_W_DEF   = 3;
    localparam int PRICE_W_DEF  = 4;
    localparam int CREDIT_W_DEF = 6;
    localparam int COIN_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COLLECT,
        DISPENSE,
        CHANGE
    } state_t;

endpackage

// File: rtl/vend_credit_acc.sv
// vend_credit_acc: saturating credit register with add and clear controls.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int CREDIT_W = CREDIT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                add,
    input  logic                clr,
    input  logic [COIN_W-1:0]   value,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] credit_nxt
);

    logic [CREDIT_W:0] sum;

    always_comb begin
        sum        = {1'b0, credit} + (CREDIT_W + 1)'(value);
        credit_nxt = !add ? credit : sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)      credit <= '0;
        else if (clr) credit <= '0;
        else          credit <= credit_nxt;

endmodule

// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: select -> price lookup -> coin collect -> dispense -> change.
// Define VEND_TIMEOUT_EN to abort COLLECT after TIMEOUT_CYCLES coinless cycles.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int ITEM_W         = ITEM_W_DEF,
    parameter int PRICE_W        = PRICE_W_DEF,
    parameter int CREDIT_W       = CREDIT_W_DEF,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_valid,
    input  logic [ITEM_W-1:0]   sel_item,
    output logic                sel_ready,
    input  logic                cancel,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_value,
    output logic                coin_ready,
    output logic [ITEM_W-1:0]   rom_addr,
    input  logic [PRICE_W-1:0]  rom_data,
    output logic                dispense_valid,
    output logic [ITEM_W-1:0]   dispense_item,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    state_t              state, state_nxt;
    logic [ITEM_W-1:0]   item_r;
    logic [PRICE_W-1:0]  price_r;
    logic [CREDIT_W-1:0] credit_nxt;
    logic                paid, coin_acc, abort, timeout;

    assign paid     = credit >= CREDIT_W'(price_r);
    assign coin_acc = coin_valid && coin_ready;
    assign abort    = state == COLLECT && !paid && (cancel || timeout);

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) idle_cnt <= '0;
        else     idle_cnt <= (state != COLLECT || coin_acc) ? '0 : idle_cnt + TW'(1);

    assign timeout = state == COLLECT && !coin_acc && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    vend_credit_acc #(.CREDIT_W(CREDIT_W)) u_acc (
        .clk        (clk),
        .rst        (rst),
        .add        (coin_acc),
        .clr        (state == CHANGE && state_nxt == IDLE),
        .value      (coin_value),
        .credit     (credit),
        .credit_nxt (credit_nxt)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = sel_valid ? LOOKUP : IDLE;
            LOOKUP:   state_nxt = rom_data == '0 ? DISPENSE : COLLECT;
            COLLECT:  state_nxt = paid ? DISPENSE : abort ? CHANGE : COLLECT;
            DISPENSE: state_nxt = CHANGE;
            CHANGE:   state_nxt = (change_amount == '0 || change_ready) ? IDLE : CHANGE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Refund uses credit_nxt so a coin accepted alongside cancel is returned too.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            item_r        <= '0;
            price_r       <= '0;
            change_amount <= '0;
        end else begin
            if (state == IDLE && sel_valid) item_r <= sel_item;
            if (state == LOOKUP) price_r <= rom_data;
            if (abort) change_amount <= credit_nxt;
            if (state == DISPENSE) change_amount <= credit - CREDIT_W'(price_r);
        end

    always_comb begin
        sel_ready      = state == IDLE;
        busy           = state != IDLE;
        coin_ready     = state == COLLECT && !paid;
        rom_addr       = item_r;
        dispense_valid = state == DISPENSE;
        dispense_item  = item_r;
        change_valid   = state == CHANGE && change_amount != '0;
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// tb_vend_txn_ctrl: scoreboard bench for vend_txn_ctrl (default and CREDIT_W=4 instances in lockstep).
module tb_vend_txn_ctrl;

    logic       clk = 0, rst = 1;
    logic       sel_valid = 0, cancel = 0, coin_valid = 0, change_ready = 0;
    logic [2:0] sel_item = 0;
    logic [3:0] coin_value = 0;

    logic       sel_ready, coin_ready, dispense_valid, change_valid, busy;
    logic [2:0] rom_addr, dispense_item;
    logic [3:0] rom_data;
    logic [5:0] change_amount, credit;

    logic       s_sel_ready, s_coin_ready, s_dispense_valid, s_change_valid, s_busy;
    logic [2:0] s_rom_addr, s_dispense_item;
    logic [3:0] s_rom_data, s_change_amount, s_credit;

    int checks = 0, failures = 0, disp_cnt = 0, n;
    logic [2:0] exp_item_q[$];
    logic [5:0] exp_chg_q[$];
    logic [3:0] exp_s_chg_q[$];
    logic [5:0] e;

    assign rom_data   = {rom_addr, 1'b0};
    assign s_rom_data = {s_rom_addr, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) if (dispense_valid) disp_cnt++;

    vend_txn_ctrl #(.TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_item(sel_item), .sel_ready(sel_ready),
        .cancel(cancel), .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready),
        .rom_addr(rom_addr), .rom_data(rom_data), .dispense_valid(dispense_valid),
        .dispense_item(dispense_item), .change_valid(change_valid), .change_amount(change_amount),
        .change_ready(change_ready), .credit(credit), .busy(busy)
    );

    vend_txn_ctrl #(.CREDIT_W(4), .TIMEOUT_CYCLES(10)) dut_s (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_item(sel_item), .sel_ready(s_sel_ready),
        .cancel(cancel), .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(s_coin_ready),
        .rom_addr(s_rom_addr), .rom_data(s_rom_data), .dispense_valid(s_dispense_valid),
        .dispense_item(s_dispense_item), .change_valid(s_change_valid), .change_amount(s_change_amount),
        .change_ready(change_ready), .credit(s_credit), .busy(s_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input logic [2:0] item);
        sel_valid = 1; sel_item = item;
        step();
        sel_valid = 0;
    endtask

    task automatic coin(input logic [3:0] v);
        coin_valid = 1; coin_value = v;
        step();
        coin_valid = 0;
    endtask

    task automatic wait_disp(input int max, output int cyc);
        cyc = 0;
        while (dispense_valid !== 1'b1 && cyc < max) begin step(); cyc++; end
        if (dispense_valid !== 1'b1) cyc = max + 1;
    endtask

    task automatic wait_chg(input int max, output int cyc);
        cyc = 0;
        while (change_valid !== 1'b1 && cyc < max) begin step(); cyc++; end
        if (change_valid !== 1'b1) cyc = max + 1;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        rst = 0;
        step();
        checks++; if (busy !== 0 || sel_ready !== 1) begin failures++; $display("FAIL reset_state busy=%0b sel_ready=%0b exp busy=0 sel_ready=1", busy, sel_ready); end
        checks++; if (credit !== 0 || change_amount !== 0 || rom_addr !== 0) begin failures++; $display("FAIL reset_regs credit=%0d chg=%0d addr=%0d exp 0 0 0", credit, change_amount, rom_addr); end
        checks++; if (dispense_valid !== 0 || change_valid !== 0 || coin_ready !== 0) begin failures++; $display("FAIL reset_strobes disp=%0b chg=%0b coin_rdy=%0b exp 0 0 0", dispense_valid, change_valid, coin_ready); end
    endtask

    task automatic test_paid();
        select(3);
        checks++; if (busy !== 1 || sel_ready !== 0) begin failures++; $display("FAIL paid_busy busy=%0b sel_ready=%0b exp 1 0", busy, sel_ready); end
        step();
        checks++; if (coin_ready !== 1) begin failures++; $display("FAIL paid_coin_ready got=%0b exp=1", coin_ready); end
        coin(5);
        checks++; if (credit !== 5) begin failures++; $display("FAIL paid_credit1 got=%0d exp=5", credit); end
        exp_item_q.push_back(3); exp_chg_q.push_back(1);
        coin(2);
        checks++; if (credit !== 7 || coin_ready !== 0) begin failures++; $display("FAIL paid_credit2 credit=%0d coin_rdy=%0b exp 7 0", credit, coin_ready); end
        wait_disp(5, n);
        checks++; if (n !== 1) begin failures++; $display("FAIL paid_disp_latency got=%0d exp=1", n); end
        e = 6'(exp_item_q.pop_front());
        checks++; if (dispense_item !== e[2:0]) begin failures++; $display("FAIL paid_disp_item got=%0d exp=%0d", dispense_item, e); end
        wait_chg(5, n);
        e = exp_chg_q.pop_front();
        checks++; if (n !== 1 || change_amount !== e) begin failures++; $display("FAIL paid_change lat=%0d amt=%0d exp lat=1 amt=%0d", n, change_amount, e); end
        change_ready = 1;
        step();
        change_ready = 0;
        checks++; if (busy !== 0 || credit !== 0 || change_valid !== 0) begin failures++; $display("FAIL paid_done busy=%0b credit=%0d chg=%0b exp 0 0 0", busy, credit, change_valid); end
    endtask

    task automatic test_free();
        exp_item_q.push_back(0);
        select(0);
        wait_disp(5, n);
        checks++; if (n + 1 !== 2) begin failures++; $display("FAIL free_disp_latency got=%0d exp=2", n + 1); end
        e = 6'(exp_item_q.pop_front());
        checks++; if (dispense_item !== e[2:0]) begin failures++; $display("FAIL free_disp_item got=%0d exp=%0d", dispense_item, e); end
        step();
        checks++; if (change_valid !== 0) begin failures++; $display("FAIL free_no_change got=%0b exp=0", change_valid); end
        step();
        checks++; if (busy !== 0) begin failures++; $display("FAIL free_idle busy=%0b exp=0", busy); end
    endtask

    task automatic test_cancel();
        int d0;
        d0 = disp_cnt;
        select(7);
        step();
        coin(4);
        exp_chg_q.push_back(6);
        cancel = 1;
        coin(2);
        cancel = 0;
        wait_chg(3, n);
        e = exp_chg_q.pop_front();
        checks++; if (n > 3 || change_amount !== e) begin failures++; $display("FAIL cancel_refund amt=%0d exp=%0d", change_amount, e); end
        change_ready = 1;
        step();
        change_ready = 0;
        checks++; if (disp_cnt !== d0 || busy !== 0 || credit !== 0) begin failures++; $display("FAIL cancel_no_disp pulses=%0d busy=%0b credit=%0d exp 0 0 0", disp_cnt - d0, busy, credit); end
    endtask

    task automatic test_saturation();
        logic [3:0] es;
        select(7);
        step();
        coin(9);
        exp_chg_q.push_back(4); exp_s_chg_q.push_back(1);
        coin(9);
        checks++; if (s_credit !== 15 || credit !== 18) begin failures++; $display("FAIL sat_credit s=%0d wide=%0d exp 15 18", s_credit, credit); end
        wait_disp(3, n);
        checks++; if (n !== 1 || s_dispense_valid !== 1) begin failures++; $display("FAIL sat_disp lat=%0d s_disp=%0b exp 1 1", n, s_dispense_valid); end
        wait_chg(3, n);
        e = exp_chg_q.pop_front(); es = exp_s_chg_q.pop_front();
        checks++; if (s_change_amount !== es || change_amount !== e) begin failures++; $display("FAIL sat_change s=%0d wide=%0d exp %0d %0d", s_change_amount, change_amount, es, e); end
        change_ready = 1;
        step();
        change_ready = 0;
        checks++; if (s_busy !== 0 || s_credit !== 0) begin failures++; $display("FAIL sat_done busy=%0b credit=%0d exp 0 0", s_busy, s_credit); end
    endtask

    task automatic test_change_hold();
        select(1);
        step();
        exp_chg_q.push_back(3);
        coin(5);
        wait_chg(4, n);
        e = exp_chg_q.pop_front();
        checks++; if (change_amount !== e) begin failures++; $display("FAIL hold_amount got=%0d exp=%0d", change_amount, e); end
        sel_valid = 1; sel_item = 5;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (change_valid !== 1 || change_amount !== e || sel_ready !== 0) begin failures++; $display("FAIL hold_cycle%0d valid=%0b amt=%0d sel_ready=%0b exp 1 %0d 0", i, change_valid, change_amount, sel_ready, e); end
        end
        sel_valid = 0; change_ready = 1;
        step();
        change_ready = 0;
        checks++; if (busy !== 0 || rom_addr !== 1 || credit !== 0) begin failures++; $display("FAIL hold_done busy=%0b addr=%0d credit=%0d exp 0 1 0", busy, rom_addr, credit); end
    endtask

    task automatic test_reset_mid();
        select(7);
        step();
        coin(4);
        checks++; if (credit !== 4 || busy !== 1) begin failures++; $display("FAIL rstmid_pre credit=%0d busy=%0b exp 4 1", credit, busy); end
        #1 rst = 1;
        #1;
        checks++; if (busy !== 0 || credit !== 0 || rom_addr !== 0 || change_amount !== 0) begin failures++; $display("FAIL rstmid_async busy=%0b credit=%0d addr=%0d chg=%0d exp 0 0 0 0", busy, credit, rom_addr, change_amount); end
        step();
        rst = 0;
        step();
        checks++; if (sel_ready !== 1 || coin_ready !== 0) begin failures++; $display("FAIL rstmid_idle sel_ready=%0b coin_ready=%0b exp 1 0", sel_ready, coin_ready); end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        select(7);
        step();
        exp_chg_q.push_back(3);
        coin(3);
        wait_chg(20, n);
        e = exp_chg_q.pop_front();
        checks++; if (n > 20 || n < 8 || change_amount !== e) begin failures++; $display("FAIL timeout_refund wait=%0d amt=%0d exp ~9 %0d", n, change_amount, e); end
        change_ready = 1;
        step();
        change_ready = 0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_paid();
        test_free();
        test_cancel();
        test_saturation();
        test_change_hold();
        test_reset_mid();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
